display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
// - Time-multiplexes NUM_DIGITS 4-bit hex digits onto one shared 7-segment hex decoder and segment bus.
// - Drives one-hot digit enables and applies anti-ghosting guard gaps between digits.
// - Takes new frames through a valid/ready handshake and double-buffers them, so frames update only at frame boundaries (no tearing).
// - Sits between the switch/register logic and the physical multi-digit 7-segment display.
// PARAMETERS
// - NUM_DIGITS    4     number of multiplexed digits (2..8)
// - REFRESH_DIV   1000  clock cycles each digit is lit (>=1)
// - GUARD_CYCLES  2     blank cycles between digits (>=0; 0 = no guard state)
// PORTS
// - clk         in   1             rising-edge clock
// - rst_n       in   1             asynchronous active-low reset
// - enable      in   1             1 = scan; 0 = all digits off
// - load_valid  in   1             new frame offered
// - load_ready  out  1             pending buffer empty, frame can be accepted
// - load_data   in   4*NUM_DIGITS  hex nibbles; digit i = [4i+3:4i]
// - load_dp     in   NUM_DIGITS    decimal point per digit
// - load_blank  in   NUM_DIGITS    1 = digit i shows no segments
// - seg_out     out  7             {g,f,e,d,c,b,a}, active-high
// - dp_out      out  1             decimal point, active-high
// - digit_en    out  NUM_DIGITS    one-hot, active-high; all zero when idle or in guard
// BEHAVIOUR
// - Reset values:
//   - all outputs 0, except load_ready = 1.
//   - active and pending frame buffers cleared to value 0, dp 0, blank all 1.
//   - digit index 0, counters 0, state OFF.
// - Handshake:
//   - Transfer happens when load_valid & load_ready on a clock edge; data goes to the pending buffer.
//   - load_ready drops the next cycle and stays low until the pending buffer is committed.
//   - load_ready never depends combinationally on load_valid.
// - Commit:
//   - The pending buffer moves to the active buffer when the index wraps from NUM_DIGITS-1 to 0.
//   - It also moves on any cycle in OFF.
//   - load_ready returns to 1 the cycle after the commit.
//   - If a commit and a new transfer occur in the same cycle, the new transfer is refused; ready is low that cycle.
// - FSM:
//   - OFF: digit_en = 0, seg_out = 0. Goes to SHOW with index 0 and count 0 when enable = 1.
//   - SHOW: digit_en = 1 << index. seg_out and dp_out come from the active buffer at index, or 0 if blank[index]. After REFRESH_DIV cycles, goes to GUARD, or directly to the next SHOW if GUARD_CYCLES = 0.
//   - GUARD: digit_en = 0, seg_out = 0, dp_out = 0 for GUARD_CYCLES cycles. Then index = (index == NUM_DIGITS-1) ? 0 : index+1 and state returns to SHOW; the wrap also triggers the commit.
//   - enable = 0 in any state returns to OFF on the next edge; outputs are 0 from that edge.
// - Timing:
//   - All outputs are registered; digit_en, seg_out and dp_out change on the same edge (glitch-free).
//   - Frame period = NUM_DIGITS * (REFRESH_DIV + GUARD_CYCLES) cycles.
//   - Accept-to-visible latency is at most one frame period plus 2 cycles.
// - Counters are sized by $clog2 of their maximum; terminal compare is on value == max-1, with no overflow.
// - Decoder map (hex 0-F to {g..a}):
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
// - rst_n asserted mid-frame: immediate async return to reset values; any pending frame is discarded.
// STRUCTURE
// - display_pkg holds:
//   - typedef seg7_t = logic [6:0]
//   - localparams SEG_BLANK = 7'h00 and the 16-entry HEX_TO_SEG table
//   - the FSM enum scan_state_e {OFF, SHOW, GUARD}
// - Sub-module seg7_hex_decoder: purely combinational, nibble to seg7_t, using HEX_TO_SEG. Its output is registered in this block.
// TESTING
// Run with NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
// - Reset, then enable=1 with frame 0x1234 (digit0 = 4), blank=0:
//   - digit_en sequence is 0001, 0000, 0010, 0000, 0100, ...
//   - seg_out is 66, 4F, 5B, 06, each held 4 cycles.
// - Load 0xABCD while digit 1 is lit:
//   - load_ready is low until the wrap.
//   - The current frame is shown unchanged until the wrap; the next frame shows 5E, 39, 7C, 77.
// - Hold load_valid continuously:
//   - Exactly one transfer happens per frame (every 20 cycles).
//   - No transfer happens in a commit cycle.
// - blank = 4'b0100, dp = 4'b0001:
//   - digit 2 slot has seg_out = 0 with digit_en = 0100.
//   - dp_out = 1 only during the digit 0 slot.
// - Drop enable mid-SHOW: the next edge gives all outputs 0; re-enable starts at digit 0 with a full 4-cycle slot.
// - Assert rst_n low mid-GUARD (asynchronously): outputs are 0 and load_ready is 1 immediately; the pending frame is lost.

Source files
------------

// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the multiplexed 7-segment display path.
//   seg7_t        : segment vector {g,f,e,d,c,b,a}, active-high
//   SEG_BLANK     : all segments off
//   HEX_TO_SEG    : hex nibble (index) to segment pattern
//   scan_state_e  : scan controller states
// ---------------------------------------------------------------------------
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  localparam seg7_t HEX_TO_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    SHOW  = 2'd1,
    GUARD = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_decoder.sv
// ---------------------------------------------------------------------------
// seg7_hex_decoder
// Purely combinational hex nibble to 7-segment pattern lookup.
//   i_nibble : 4-bit hex value
//   o_seg    : {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module seg7_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  assign o_seg = HEX_TO_SEG[i_nibble];

endmodule

// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus with
// one-hot digit enables and blank guard gaps between digits. New frames
// arrive over a valid/ready handshake into a pending buffer and are copied
// to the active buffer only at frame boundaries (or while OFF).
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : 1 = scan, 0 = all digits off
//   load_valid   : frame offered
//   load_ready   : pending buffer empty
//   load_data    : nibble per digit, digit i = [4i+3:4i]
//   load_dp      : decimal point per digit
//   load_blank   : 1 = digit shows no segments
//   seg_out      : {g,f,e,d,c,b,a}, registered
//   dp_out       : decimal point, registered
//   digit_en     : one-hot digit enable, registered
// ---------------------------------------------------------------------------
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  output seg7_t                   seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  // Scan state
  scan_state_e         r_state;
  logic [IDX_W-1:0]    r_index;
  logic [CNT_W-1:0]    r_cnt;
  logic [GCNT_W-1:0]   r_gcnt;

  scan_state_e         w_state_next;
  logic [IDX_W-1:0]    w_index_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [GCNT_W-1:0]   w_gcnt_next;
  logic [IDX_W-1:0]    w_index_inc;
  logic                w_wrap;

  // Frame buffers
  logic [4*NUM_DIGITS-1:0] r_act_data,  r_pend_data;
  logic [NUM_DIGITS-1:0]   r_act_dp,    r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank, r_pend_blank;
  logic                    r_pend_full;
  logic                    r_load_ready;

  logic [4*NUM_DIGITS-1:0] w_act_data_next;
  logic [NUM_DIGITS-1:0]   w_act_dp_next;
  logic [NUM_DIGITS-1:0]   w_act_blank_next;
  logic                    w_commit;
  logic                    w_xfer;
  logic                    w_pend_full_next;

  // Output path
  logic [3:0]            w_nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_onehot;
  seg7_t                 w_dec_seg;
  seg7_t                 w_seg_next;
  logic                  w_dp_next;
  logic [NUM_DIGITS-1:0] w_digit_en_next;
  seg7_t                 r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_digit_en;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_index <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      r_cnt   <= w_cnt_next;
      r_gcnt  <= w_gcnt_next;
    end
  end

  assign w_index_inc = (r_index == IDX_LAST) ? '0 : r_index + 1'b1;

  // ---------------- FSM: next-state logic ----------------
  // w_wrap flags the edge where the index rolls over to digit 0, which is
  // the frame boundary used for committing the pending frame.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_cnt_next   = r_cnt;
    w_gcnt_next  = r_gcnt;
    w_wrap       = 1'b0;
    if (!enable) begin
      w_state_next = OFF;
      w_index_next = '0;
      w_cnt_next   = '0;
      w_gcnt_next  = '0;
    end else begin
      unique case (r_state)
        OFF: begin
          w_state_next = SHOW;
          w_index_next = '0;
          w_cnt_next   = '0;
        end
        SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_next = '0;
            if (GUARD_CYCLES > 0) begin
              w_state_next = GUARD;
              w_gcnt_next  = '0;
            end else begin
              w_index_next = w_index_inc;
              w_wrap       = (r_index == IDX_LAST);
            end
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        GUARD: begin
          if (r_gcnt == GCNT_LAST) begin
            w_state_next = SHOW;
            w_cnt_next   = '0;
            w_index_next = w_index_inc;
            w_wrap       = (r_index == IDX_LAST);
          end else begin
            w_gcnt_next = r_gcnt + 1'b1;
          end
        end
        default: begin
          w_state_next = OFF;
        end
      endcase
    end
  end

  // ---------------- Handshake and double buffer ----------------
  // Commit requires a full pending buffer, and a transfer requires an empty
  // one, so a commit cycle can never also accept a new frame.
  assign w_commit         = r_pend_full & ((r_state == OFF) | w_wrap);
  assign w_xfer           = load_valid & r_load_ready;
  assign w_pend_full_next = w_xfer | (r_pend_full & ~w_commit);

  assign w_act_data_next  = w_commit ? r_pend_data  : r_act_data;
  assign w_act_dp_next    = w_commit ? r_pend_dp    : r_act_dp;
  assign w_act_blank_next = w_commit ? r_pend_blank : r_act_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '1;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '1;
      r_pend_full  <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_act_data  <= w_act_data_next;
      r_act_dp    <= w_act_dp_next;
      r_act_blank <= w_act_blank_next;
      if (w_xfer) begin
        r_pend_data  <= load_data;
        r_pend_dp    <= load_dp;
        r_pend_blank <= load_blank;
      end
      r_pend_full  <= w_pend_full_next;
      r_load_ready <= ~w_pend_full_next;
    end
  end

  // ---------------- FSM: output logic ----------------
  // Outputs are decoded from the post-edge state and buffer contents and
  // then registered, so enables, segments and dp all switch on one edge.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_nibble[gi] = w_act_data_next[4*gi +: 4];
    assign w_onehot[gi] = (w_index_next == IDX_W'(gi));
  end

  seg7_hex_decoder u_decoder (
    .i_nibble (w_nibble[w_index_next]),
    .o_seg    (w_dec_seg)
  );

  always_comb begin
    w_digit_en_next = '0;
    w_seg_next      = SEG_BLANK;
    w_dp_next       = 1'b0;
    if (w_state_next == SHOW) begin
      w_digit_en_next = w_onehot;
      if (!w_act_blank_next[w_index_next]) begin
        w_seg_next = w_dec_seg;
        w_dp_next  = w_act_dp_next[w_index_next];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= SEG_BLANK;
      r_dp       <= 1'b0;
      r_digit_en <= '0;
    end else begin
      r_seg      <= w_seg_next;
      r_dp       <= w_dp_next;
      r_digit_en <= w_digit_en_next;
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign digit_en   = r_digit_en;
  assign load_ready = r_load_ready;

endmodule

// File: tb/tb_display_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_display_scan_controller
// Checks the scan controller against a frame-time model: the display is
// described by the position inside a 20-cycle frame (4 digits x 5 cycles),
// plus directed literal expectations taken from the decoder table.
// ---------------------------------------------------------------------------
module tb_display_scan_controller;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 1;
  localparam int SLOT  = R + G;
  localparam int FRAME = N * SLOT;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         load_valid;
  logic         load_ready;
  logic [15:0]  load_data;
  logic [3:0]   load_dp;
  logic [3:0]   load_blank;
  logic [6:0]   seg_out;
  logic         dp_out;
  logic [3:0]   digit_en;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = -100;
  bit hold_mon = 1'b0;
  int xfer_q[$];

  display_scan_controller #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_en   (digit_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // ---------------- frame-time model ----------------
  bit          m_on;
  int          m_t;
  logic [15:0] m_act_data, m_pend_data;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic [3:0]  m_act_blank, m_pend_blank;
  bit          m_pend_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on         <= 1'b0;
      m_t          <= 0;
      m_act_data   <= '0;
      m_act_dp     <= '0;
      m_act_blank  <= '1;
      m_pend_data  <= '0;
      m_pend_dp    <= '0;
      m_pend_blank <= '1;
      m_pend_full  <= 1'b0;
    end else begin
      // A new frame starts when the last cycle of a frame elapses; while
      // off, any waiting frame is taken over immediately.
      if (m_pend_full && (!m_on || (enable && m_t == FRAME - 1))) begin
        m_act_data  <= m_pend_data;
        m_act_dp    <= m_pend_dp;
        m_act_blank <= m_pend_blank;
        m_pend_full <= 1'b0;
      end
      if (load_valid && !m_pend_full) begin
        m_pend_data  <= load_data;
        m_pend_dp    <= load_dp;
        m_pend_blank <= load_blank;
        m_pend_full  <= 1'b1;
      end
      m_on <= enable;
      m_t  <= (!enable || !m_on) ? 0 : (m_t + 1) % FRAME;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d;
    if (load_valid && load_ready) begin
      $display("xfer edge k=%0d data=%h dp=%b blank=%b", k + 1, load_data, load_dp, load_blank);
      if (hold_mon) xfer_q.push_back(k + 1);
    end
    #1;
    e_en  = '0;
    e_seg = '0;
    e_dp  = 1'b0;
    if (m_on && (m_t % SLOT) < R) begin
      d       = m_t / SLOT;
      e_en[d] = 1'b1;
      if (!m_act_blank[d]) begin
        e_seg = SEG_REF[m_act_data[d*4 +: 4]];
        e_dp  = m_act_dp[d];
      end
    end
    check("model_digit_en",   32'(digit_en),   32'(e_en));
    check("model_seg_out",    32'(seg_out),    32'(e_seg));
    check("model_dp_out",     32'(dp_out),     32'(e_dp));
    check("model_load_ready", 32'(load_ready), 32'(!m_pend_full));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic go_to(input int target);
    while (k < target) tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    load_blank = '0;
    tick();
    tick();
    check("reset_digit_en",   32'(digit_en),   32'h0);
    check("reset_seg_out",    32'(seg_out),    32'h0);
    check("reset_dp_out",     32'(dp_out),     32'h0);
    check("reset_load_ready", 32'(load_ready), 32'h1);
    rst_n = 1'b1;

    // Frame 0x1234 loaded while off, committed on the following OFF cycle.
    load_data  = 16'h1234;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("ready_low_after_xfer", 32'(load_ready), 32'h0);
    tick();
    check("ready_back_off_commit", 32'(load_ready), 32'h1);
    enable = 1'b1;
    tick();
    k = 0;
    check("k0_digit_en", 32'(digit_en), 32'h1);
    check("k0_seg",      32'(seg_out),  32'h66);
    go_to(4);
    check("k4_guard_en",  32'(digit_en), 32'h0);
    check("k4_guard_seg", 32'(seg_out),  32'h0);
    go_to(5);
    check("k5_digit_en", 32'(digit_en), 32'h2);
    check("k5_seg",      32'(seg_out),  32'h4F);

    // Offer 0xABCD while digit 1 is lit.
    load_data  = 16'hABCD;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("k6_ready_low", 32'(load_ready), 32'h0);
    go_to(10);
    check("k10_digit_en", 32'(digit_en), 32'h4);
    check("k10_seg",      32'(seg_out),  32'h5B);
    go_to(15);
    check("k15_digit_en", 32'(digit_en), 32'h8);
    check("k15_seg_old_frame", 32'(seg_out), 32'h06);
    go_to(19);
    check("k19_ready_low", 32'(load_ready), 32'h0);
    go_to(20);
    check("k20_seg_new_frame", 32'(seg_out),    32'h5E);
    check("k20_ready_back",    32'(load_ready), 32'h1);

    // Hold load_valid for three frames with changing data.
    hold_mon   = 1'b1;
    load_valid = 1'b1;
    while (k < 80) begin
      load_data = 16'($urandom);
      load_dp   = 4'($urandom);
      tick();
      case (k)
        25: check("k25_seg", 32'(seg_out), 32'h39);
        30: check("k30_seg", 32'(seg_out), 32'h7C);
        35: check("k35_seg", 32'(seg_out), 32'h77);
        default: ;
      endcase
    end
    hold_mon = 1'b0;
    check("hold_xfer_count", 32'(xfer_q.size()), 32'd3);
    if (xfer_q.size() == 3) begin
      check("hold_xfer0_edge", 32'(xfer_q[0]), 32'd21);
      check("hold_xfer1_edge", 32'(xfer_q[1]), 32'd41);
      check("hold_xfer2_edge", 32'(xfer_q[2]), 32'd61);
    end

    // Blank digit 2, decimal point on digit 0.
    load_data  = 16'h5678;
    load_dp    = 4'b0001;
    load_blank = 4'b0100;
    tick();
    load_valid = 1'b0;
    go_to(100);
    check("k100_digit_en", 32'(digit_en), 32'h1);
    check("k100_seg",      32'(seg_out),  32'h7F);
    check("k100_dp",       32'(dp_out),   32'h1);
    go_to(105);
    check("k105_seg", 32'(seg_out), 32'h07);
    check("k105_dp",  32'(dp_out),  32'h0);
    go_to(110);
    check("k110_digit_en_blank", 32'(digit_en), 32'h4);
    check("k110_seg_blank",      32'(seg_out),  32'h0);
    check("k110_dp",             32'(dp_out),   32'h0);
    go_to(115);
    check("k115_seg", 32'(seg_out), 32'h6D);

    // Drop enable mid-SHOW, then re-enable.
    go_to(116);
    enable = 1'b0;
    tick();
    check("off_digit_en", 32'(digit_en), 32'h0);
    check("off_seg",      32'(seg_out),  32'h0);
    check("off_dp",       32'(dp_out),   32'h0);
    go_to(119);
    enable = 1'b1;
    tick();
    check("reen_digit_en", 32'(digit_en), 32'h1);
    check("reen_seg",      32'(seg_out),  32'h7F);
    load_data  = 16'h9999;
    load_dp    = 4'b0000;
    load_blank = 4'b0000;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("k121_ready_low", 32'(load_ready), 32'h0);
    go_to(123);
    check("k123_slot_full", 32'(digit_en), 32'h1);
    go_to(124);
    check("k124_guard_en", 32'(digit_en), 32'h0);

    // Asynchronous reset in the middle of the guard cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_digit_en", 32'(digit_en),   32'h0);
    check("async_rst_seg",      32'(seg_out),    32'h0);
    check("async_rst_dp",       32'(dp_out),     32'h0);
    check("async_rst_ready",    32'(load_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_digit_en",     32'(digit_en),   32'h1);
    check("post_rst_pending_lost", 32'(seg_out),    32'h0);
    check("post_rst_ready",        32'(load_ready), 32'h1);
    go_to(k + 5);
    check("post_rst_digit1_en",  32'(digit_en), 32'h2);
    check("post_rst_digit1_seg", 32'(seg_out),  32'h0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
